// File: rtl/lane_symbol_aligner.sv
// Per-lane receive symbol aligner.
// Finds 10-bit symbol boundaries in a recovered serial bit stream by locking onto the
// K28.5 comma (COM). Once LOCK_COMMAS boundary-aligned commas have been seen, each
// further boundary emits one aligned symbol towards the 8b10b decoder.
//
// Ports:
//   clk_i            bit clock
//   rst_i            asynchronous reset, active-low
//   enable_i         lane enable; low forces the unlocked state and suppresses output
//   bit_i            received serial bit, first-transmitted bit ('a') first
//   bit_valid_i      bit_i qualifier; bits are consumed only when high
//   symbol_o         aligned symbol, [0] = first received bit
//   symbol_valid_o   one-cycle pulse per emitted symbol
//   symbol_is_com_o  symbol_o is a COM (either disparity); qualified by symbol_valid_o
//   aligned_o        lane locked
//   realign_count_o  saturating count of lock losses
module lane_symbol_aligner #(
  parameter int unsigned LOCK_COMMAS = 4,
  parameter logic [9:0]  COM_RDN     = 10'h17C,
  parameter logic [9:0]  COM_RDP     = 10'h283
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic [9:0] symbol_o,
  output logic       symbol_valid_o,
  output logic       symbol_is_com_o,
  output logic       aligned_o,
  output logic [7:0] realign_count_o
);

  typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

  state_e     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] good_q, good_d;
  logic [9:0] symbol_q, symbol_d;
  logic       symbol_valid_d;
  logic       symbol_is_com_q, symbol_is_com_d;
  logic       aligned_q, aligned_d;
  logic [7:0] realign_q, realign_d;

  logic       match;
  logic       boundary;
  logic [3:0] cnt_inc;
  logic [4:0] good_inc;

  always_comb begin
    sr_d            = sr_q;
    cnt_d           = cnt_q;
    good_d          = good_q;
    state_d         = state_q;
    symbol_d        = symbol_q;
    symbol_valid_d  = 1'b0;
    symbol_is_com_d = symbol_is_com_q;
    realign_d       = realign_q;

    if (bit_valid_i) begin
      sr_d = {bit_i, sr_q[9:1]};
    end
    // Comma detection looks at the window that includes the bit arriving this cycle.
    match    = bit_valid_i && ((sr_d == COM_RDN) || (sr_d == COM_RDP));
    boundary = bit_valid_i && (cnt_q == 4'd9);
    cnt_inc  = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
    good_inc = {1'b0, good_q} + 5'd1;

    if (!enable_i) begin
      state_d = StUnlocked;
      cnt_d   = 4'd0;
      good_d  = 4'd0;
    end else if (bit_valid_i) begin
      case (state_q)
        StUnlocked: begin
          cnt_d = 4'd0;
          if (match) begin
            good_d  = 4'd1;
            state_d = (LOCK_COMMAS <= 1) ? StLocked : StLocking;
          end
        end
        StLocking: begin
          cnt_d = cnt_inc;
          if (boundary) begin
            if (match) begin
              good_d = good_inc[3:0];
              // >= so that a single-comma lock can also recover after a slip.
              if (good_inc >= 5'(LOCK_COMMAS)) begin
                state_d = StLocked;
              end
            end
          end else if (match) begin
            // Comma off the current grid: re-anchor on it.
            cnt_d  = 4'd0;
            good_d = 4'd1;
          end
        end
        StLocked: begin
          cnt_d = cnt_inc;
          if (boundary) begin
            symbol_d        = sr_d;
            symbol_valid_d  = 1'b1;
            symbol_is_com_d = match;
          end else if (match) begin
            cnt_d   = 4'd0;
            good_d  = 4'd1;
            state_d = StLocking;
            if (realign_q != 8'hFF) begin
              realign_d = realign_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = StUnlocked;
          cnt_d   = 4'd0;
          good_d  = 4'd0;
        end
      endcase
    end

    aligned_d = (state_d == StLocked);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= StUnlocked;
      sr_q            <= 10'd0;
      cnt_q           <= 4'd0;
      good_q          <= 4'd0;
      symbol_q        <= 10'd0;
      symbol_valid_o  <= 1'b0;
      symbol_is_com_q <= 1'b0;
      aligned_q       <= 1'b0;
      realign_q       <= 8'd0;
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      cnt_q           <= cnt_d;
      good_q          <= good_d;
      symbol_q        <= symbol_d;
      symbol_valid_o  <= symbol_valid_d;
      symbol_is_com_q <= symbol_is_com_d;
      aligned_q       <= aligned_d;
      realign_q       <= realign_d;
    end
  end

  assign symbol_o        = symbol_q;
  assign symbol_is_com_o = symbol_is_com_q;
  assign aligned_o       = aligned_q;
  assign realign_count_o = realign_q;

endmodule
